sc_randreg_bank: RTL
====================

Name: sc_randreg_bank

Overview:
- Parametrised successor to the single random-source/general-register pair: a free-running Galois LFSR feeding a bank of CHANNELS registers of DATAWIDTH bits.
- The bank includes the clear/load command FSM internally, so no separate state machine is needed.
- Sits after the button debouncers; takes debounced active-low clear/load levels.
- Each new press produces exactly one write or one clear. Writes go to a selected channel, or to successive channels in round-robin mode.

Parameters:
- DATAWIDTH, 8, width of LFSR and of each channel register.
- CHANNELS, 4, number of bank registers; must be ≥2.
- SEED, 8'hA5, LFSR reset value, DATAWIDTH bits, must be nonzero.
- TAPS, 8'hB8, Galois feedback mask, DATAWIDTH bits.
- PTRWIDTH, 2, pointer/select width; must be ≥ clog2(CHANNELS).

Ports:
- SC_RANDREGBANK_CLOCK_50  in  1  system clock.
- SC_RANDREGBANK_RESET_InHigh  in  1  asynchronous reset, active high.
- SC_RANDREGBANK_clear_InLow  in  1  debounced clear button level, active low.
- SC_RANDREGBANK_load_InLow  in  1  debounced load button level, active low.
- SC_RANDREGBANK_mode_In  in  1  0 = load into chsel, 1 = round-robin.
- SC_RANDREGBANK_chsel_InBUS  in  PTRWIDTH  target channel when mode=0.
- SC_RANDREGBANK_data_OutBUS  out  DATAWIDTH*CHANNELS  flattened bank; channel k at bits [k*DATAWIDTH +: DATAWIDTH].
- SC_RANDREGBANK_lfsr_OutBUS  out  DATAWIDTH  current LFSR state.
- SC_RANDREGBANK_ptr_OutBUS  out  PTRWIDTH  round-robin pointer.
- SC_RANDREGBANK_done_Out  out  1  one-cycle pulse on a completed write or clear.
- SC_RANDREGBANK_err_Out  out  1  one-cycle pulse on a rejected load.

Behaviour:
- Reset (async, high): all channels 0, lfsr=SEED, ptr=0, done=0, err=0, FSM=IDLE. Edge-detect history registers reset to 1 (released).
- LFSR advances every clock, including while the FSM is busy: next = lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1. If lfsr==0 (illegal state), next = SEED.
- Command detection: a command is a registered falling edge, i.e. previous sample 1 and current sample 0. If clear and load edges arrive in the same cycle, clear wins and the load is dropped.
- FSM states: IDLE, LOAD, CLEAR, WAIT_RELEASE.
  - IDLE: clear edge → CLEAR; load edge → LOAD; otherwise stay.
  - LOAD:
    - Target is chsel (mode=0) or ptr (mode=1), with mode and chsel sampled in this cycle.
    - If target < CHANNELS: channel[target] <= lfsr as it is in this cycle; done=1 next cycle. In mode 1, ptr <= (ptr==CHANNELS-1) ? 0 : ptr+1.
    - If target ≥ CHANNELS: no write, ptr unchanged, err=1 next cycle.
    - Next state: WAIT_RELEASE.
  - CLEAR: all channels <= 0, ptr <= 0, done=1 next cycle → WAIT_RELEASE.
  - WAIT_RELEASE: stay until both clear_InLow and load_InLow are 1, then → IDLE. Edges seen in this state are ignored; no queuing.
- Latency: edge sampled in cycle N → LOAD/CLEAR in N+1 → register value and done visible in N+2.
- Outputs are driven directly from registers; no combinational path from inputs to outputs.
- Reset asserted mid-command aborts the command immediately; all state returns to reset values.

Optional Feature:
- Macro SC_RANDREGBANK_SEEDLOAD_EN.
- When defined:
  - Extra input SC_RANDREGBANK_seed_InBUS [DATAWIDTH-1:0].
  - The CLEAR state also loads lfsr <= seed_InBUS, or SEED if seed_InBUS==0.
  - The LFSR does not advance in the CLEAR cycle.
- When undefined: the port is absent and CLEAR does not touch the LFSR.

Test Plan:
- Reset release, defaults (SEED=A5, TAPS=B8) → lfsr_OutBUS = EA, 75, 82, 41 on the 1st–4th clocks; data_OutBUS=0; ptr=0.
- mode=0, chsel=2, press load with edge sampled at N → channel2 = lfsr value at N+1, visible at N+2; done high for exactly 1 cycle; other channels remain 0.
- mode=1, four presses each followed by release → channels 0,1,2,3 written in order; ptr goes 1,2,3,0; a held press produces only one write.
- Clear and load falling in the same cycle with bank nonzero → all channels 0, ptr=0, single done pulse, no write.
- CHANNELS=3, mode=0, chsel=3, press load → err pulse for 1 cycle, no done, bank unchanged.
- Reset asserted during LOAD → channels 0 and lfsr=A5 immediately; no done pulse. With SEEDLOAD_EN and seed_InBUS=3C, clear → lfsr=3C the cycle after CLEAR.

Source files
------------

// File: rtl/sc_randreg_bank.sv
// sc_randreg_bank: free-running Galois LFSR feeding a bank of CHANNELS registers, with a built-in clear/load command FSM
//
// Inputs:
//   SC_RANDREGBANK_CLOCK_50       clock
//   SC_RANDREGBANK_RESET_InHigh   asynchronous reset, active high
//   SC_RANDREGBANK_clear_InLow    debounced clear button level, active low
//   SC_RANDREGBANK_load_InLow     debounced load button level, active low
//   SC_RANDREGBANK_mode_In        0 = load into chsel, 1 = round-robin
//   SC_RANDREGBANK_chsel_InBUS    target channel in mode 0
//   SC_RANDREGBANK_seed_InBUS     reseed value for CLEAR (only with SC_RANDREGBANK_SEEDLOAD_EN)
// Outputs:
//   SC_RANDREGBANK_data_OutBUS    flattened bank, channel k at [k*DATAWIDTH +: DATAWIDTH]
//   SC_RANDREGBANK_lfsr_OutBUS    current LFSR state
//   SC_RANDREGBANK_ptr_OutBUS     round-robin pointer
//   SC_RANDREGBANK_done_Out       one-cycle pulse on a completed write or clear
//   SC_RANDREGBANK_err_Out        one-cycle pulse on a rejected load
// Optional feature macro: SC_RANDREGBANK_SEEDLOAD_EN (CLEAR also reseeds the LFSR).
module sc_randreg_bank #(
  parameter int DATAWIDTH = 8,
  parameter int CHANNELS = 4,
  parameter logic [DATAWIDTH-1:0] SEED = 8'hA5,
  parameter logic [DATAWIDTH-1:0] TAPS = 8'hB8,
  parameter int PTRWIDTH = 2
) (
  input  logic                          SC_RANDREGBANK_CLOCK_50,
  input  logic                          SC_RANDREGBANK_RESET_InHigh,
  input  logic                          SC_RANDREGBANK_clear_InLow,
  input  logic                          SC_RANDREGBANK_load_InLow,
  input  logic                          SC_RANDREGBANK_mode_In,
  input  logic [PTRWIDTH-1:0]           SC_RANDREGBANK_chsel_InBUS,
`ifdef SC_RANDREGBANK_SEEDLOAD_EN
  input  logic [DATAWIDTH-1:0]          SC_RANDREGBANK_seed_InBUS,
`endif
  output logic [DATAWIDTH*CHANNELS-1:0] SC_RANDREGBANK_data_OutBUS,
  output logic [DATAWIDTH-1:0]          SC_RANDREGBANK_lfsr_OutBUS,
  output logic [PTRWIDTH-1:0]           SC_RANDREGBANK_ptr_OutBUS,
  output logic                          SC_RANDREGBANK_done_Out,
  output logic                          SC_RANDREGBANK_err_Out
);
  typedef enum logic [1:0] {IDLE, LOAD, CLEAR, WAIT_RELEASE} state_t;
  state_t state_q, state_d;
  logic [DATAWIDTH*CHANNELS-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [PTRWIDTH-1:0] ptr_q, ptr_d, ptr_next, target;
  logic done_q, done_d, err_q, err_d;
  logic clr_prev_q, ld_prev_q;
  logic clr_edge, ld_edge, released, tgt_ok;

  assign clr_edge = clr_prev_q & ~SC_RANDREGBANK_clear_InLow;
  assign ld_edge = ld_prev_q & ~SC_RANDREGBANK_load_InLow;
  assign released = SC_RANDREGBANK_clear_InLow & SC_RANDREGBANK_load_InLow;
  assign target = SC_RANDREGBANK_mode_In ? ptr_q : SC_RANDREGBANK_chsel_InBUS;
  assign tgt_ok = 32'(target) < CHANNELS;
  assign ptr_next = (ptr_q == PTRWIDTH'(CHANNELS - 1)) ? '0 : ptr_q + PTRWIDTH'(1);
  // all-zero is a lock-up state for the LFSR, so recover to SEED
  assign lfsr_step = (lfsr_q == '0) ? SEED : lfsr_q[0] ? (lfsr_q >> 1) ^ TAPS : lfsr_q >> 1;

  always_ff @(posedge SC_RANDREGBANK_CLOCK_50 or posedge SC_RANDREGBANK_RESET_InHigh) begin
    if (SC_RANDREGBANK_RESET_InHigh) begin
      state_q <= IDLE;
      data_q <= '0;
      lfsr_q <= SEED;
      ptr_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      clr_prev_q <= 1'b1;
      ld_prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      lfsr_q <= lfsr_d;
      ptr_q <= ptr_d;
      done_q <= done_d;
      err_q <= err_d;
      clr_prev_q <= SC_RANDREGBANK_clear_InLow;
      ld_prev_q <= SC_RANDREGBANK_load_InLow;
    end
  end

  // clear wins over a simultaneous load; edges outside IDLE are dropped
  always_comb begin
    state_d = (state_q == IDLE) ? (clr_edge ? CLEAR : ld_edge ? LOAD : IDLE) :
              (state_q == WAIT_RELEASE) ? (released ? IDLE : WAIT_RELEASE) : WAIT_RELEASE;
  end

  always_comb begin
    data_d = data_q;
    ptr_d = ptr_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef SC_RANDREGBANK_SEEDLOAD_EN
    lfsr_d = (state_q == CLEAR) ? ((SC_RANDREGBANK_seed_InBUS == '0) ? SEED : SC_RANDREGBANK_seed_InBUS) : lfsr_step;
`else
    lfsr_d = lfsr_step;
`endif
    if (state_q == CLEAR) begin
      data_d = '0;
      ptr_d = '0;
      done_d = 1'b1;
    end else if (state_q == LOAD) begin
      if (tgt_ok) begin
        data_d[target*DATAWIDTH +: DATAWIDTH] = lfsr_q;
        ptr_d = SC_RANDREGBANK_mode_In ? ptr_next : ptr_q;
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign SC_RANDREGBANK_data_OutBUS = data_q;
  assign SC_RANDREGBANK_lfsr_OutBUS = lfsr_q;
  assign SC_RANDREGBANK_ptr_OutBUS = ptr_q;
  assign SC_RANDREGBANK_done_Out = done_q;
  assign SC_RANDREGBANK_err_Out = err_q;
endmodule
